// File: rtl/wb_bram_port_arbiter.sv
// Two-master round-robin arbiter in front of one Wishbone BRAM port.
// Grant is held for a whole bus cycle; strobes pass through, acks are registered.
module wb_bram_port_arbiter #(
  parameter int AW = 10,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_cyc,
  input  logic          m0_stb,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_stall,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_cyc,
  input  logic          m1_stb,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_stall,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic          bram_en,
  output logic          bram_we,
  output logic [AW-1:0] bram_addr,
  output logic [DW-1:0] bram_wdata,
  input  logic [DW-1:0] bram_rdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

  state_t state_q, state_d;
  logic   last_grant_q, last_grant_d;
  logic   m0_ack_q, m0_ack_d;
  logic   m1_ack_q, m1_ack_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      m0_ack_q     <= 1'b0;
      m1_ack_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      m0_ack_q     <= m0_ack_d;
      m1_ack_q     <= m1_ack_d;
    end
  end

  // Owners always return through IDLE, so a handover costs one dead cycle.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (m0_cyc && (!m1_cyc || last_grant_q)) begin
          state_d      = OWN0;
          last_grant_d = 1'b0;
        end else if (m1_cyc) begin
          state_d      = OWN1;
          last_grant_d = 1'b1;
        end
      end
      OWN0:    if (!m0_cyc) state_d = IDLE;
      OWN1:    if (!m1_cyc) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m0_stall   = 1'b1;
    m1_stall   = 1'b1;
    bram_en    = 1'b0;
    bram_we    = 1'b0;
    bram_addr  = m0_addr;
    bram_wdata = m0_wdata;
    m0_ack_d   = 1'b0;
    m1_ack_d   = 1'b0;
    case (state_q)
      OWN0: begin
        m0_stall = 1'b0;
        bram_en  = m0_cyc && m0_stb;
        bram_we  = m0_cyc && m0_stb && m0_we;
        m0_ack_d = m0_cyc && m0_stb;
      end
      OWN1: begin
        m1_stall   = 1'b0;
        bram_en    = m1_cyc && m1_stb;
        bram_we    = m1_cyc && m1_stb && m1_we;
        bram_addr  = m1_addr;
        bram_wdata = m1_wdata;
        m1_ack_d   = m1_cyc && m1_stb;
      end
      default: ;
    endcase
  end

  // A master that drops cyc has abandoned the cycle: swallow the ack still in flight.
  assign m0_ack   = m0_ack_q && m0_cyc;
  assign m1_ack   = m1_ack_q && m1_cyc;
  assign m0_rdata = bram_rdata;
  assign m1_rdata = bram_rdata;

endmodule

// File: tb/tb_wb_bram_port_arbiter.sv
// Bench for wb_bram_port_arbiter: BRAM stub, transaction-level reference model
// checked every cycle, and directed scenarios with literal expectations.
module tb_wb_bram_port_arbiter;
  localparam int AW = 10;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          m0_cyc = 0, m0_stb = 0, m0_we = 0;
  logic [AW-1:0] m0_addr = '0;
  logic [DW-1:0] m0_wdata = '0;
  logic          m0_stall, m0_ack;
  logic [DW-1:0] m0_rdata;
  logic          m1_cyc = 0, m1_stb = 0, m1_we = 0;
  logic [AW-1:0] m1_addr = '0;
  logic [DW-1:0] m1_wdata = '0;
  logic          m1_stall, m1_ack;
  logic [DW-1:0] m1_rdata;
  logic          bram_en, bram_we;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_wdata;
  logic [DW-1:0] bram_rdata;

  always #5 clk = ~clk;

  wb_bram_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_stall(m0_stall), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_stall(m1_stall), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_wdata(bram_wdata), .bram_rdata(bram_rdata)
  );

  // Unwritten locations read back a fixed address-derived pattern.
  function automatic logic [7:0] pat(input logic [AW-1:0] a);
    return a[7:0] ^ 8'h3C;
  endfunction

  bit [7:0] stub_mem [1024];
  bit       stub_wr  [1024];
  always @(posedge clk) begin
    if (bram_en) begin
      bram_rdata <= stub_wr[bram_addr] ? stub_mem[bram_addr] : pat(bram_addr);
      if (bram_we) begin
        stub_mem[bram_addr] <= bram_wdata;
        stub_wr[bram_addr]  <= 1'b1;
      end
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: who owns the port, who won last, which acks are owed.
  bit       m_valid = 0;
  int       m_owner = -1;
  int       m_last  = 1;
  bit       m_due    [2];
  bit       m_due_rd [2];
  bit [7:0] m_due_dat[2];
  bit [7:0] sh_mem [1024];
  bit       sh_wr  [1024];

  task automatic model_step();
    logic [1:0]    cyc, stb, we;
    logic [AW-1:0] ad [2];
    logic [DW-1:0] wd [2];
    logic          ack_act [2];
    logic [DW-1:0] rd_act  [2];
    bit            acc, ack_e;
    int            o;
    cyc = {m1_cyc, m0_cyc};
    stb = {m1_stb, m0_stb};
    we  = {m1_we,  m0_we};
    ad[0] = m0_addr;  ad[1] = m1_addr;
    wd[0] = m0_wdata; wd[1] = m1_wdata;
    ack_act[0] = m0_ack;   ack_act[1] = m1_ack;
    rd_act[0]  = m0_rdata; rd_act[1]  = m1_rdata;
    if (!m_valid) begin
      if (reset) begin
        m_valid = 1;
        m_owner = -1;
        m_last  = 1;
        m_due[0] = 0;
        m_due[1] = 0;
      end
      return;
    end
    o   = m_owner;
    acc = (o >= 0) && cyc[o] && stb[o];
    chk("m0_stall", m0_stall, o != 0);
    chk("m1_stall", m1_stall, o != 1);
    chk("bram_en", bram_en, acc);
    if (acc) begin
      chk("bram_we", bram_we, we[o]);
      chk("bram_addr", bram_addr, ad[o]);
      if (we[o]) chk("bram_wdata", bram_wdata, wd[o]);
    end else begin
      chk("bram_we_idle", bram_we, 0);
    end
    for (int n = 0; n < 2; n++) begin
      ack_e = m_due[n] && cyc[n];
      chk(n == 0 ? "m0_ack" : "m1_ack", ack_act[n], ack_e);
      if (ack_e && m_due_rd[n]) chk(n == 0 ? "m0_rdata" : "m1_rdata", rd_act[n], m_due_dat[n]);
    end
    // Advance to the state after the coming rising edge.
    for (int n = 0; n < 2; n++) begin
      m_due[n] = acc && (o == n);
      if (m_due[n]) begin
        m_due_rd[n]  = !we[o];
        m_due_dat[n] = sh_wr[ad[o]] ? sh_mem[ad[o]] : pat(ad[o]);
      end
    end
    if (acc && we[o]) begin
      sh_mem[ad[o]] = wd[o];
      sh_wr[ad[o]]  = 1;
    end
    if (reset) begin
      m_owner  = -1;
      m_last   = 1;
      m_due[0] = 0;
      m_due[1] = 0;
    end else if (o < 0) begin
      if (cyc[0] && cyc[1]) m_owner = (m_last == 1) ? 0 : 1;
      else if (cyc[0])      m_owner = 0;
      else if (cyc[1])      m_owner = 1;
      if (m_owner >= 0) m_last = m_owner;
    end else if (!cyc[o]) begin
      m_owner = -1;
    end
  endtask

  task automatic sample();
    @(negedge clk);
    model_step();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc1();
    sample();
    tick();
  endtask

  logic [7:0] exp4 [4];

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running, expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    exp4[0] = 8'h3C; exp4[1] = 8'h3D; exp4[2] = 8'h3E; exp4[3] = 8'h3F;
    reset = 1;
    tick();
    repeat (3) cyc1();
    reset = 0;
    sample();
    chk("rst_m0_stall", m0_stall, 1);
    chk("rst_m1_stall", m1_stall, 1);
    chk("rst_bram_en", bram_en, 0);
    chk("rst_bram_we", bram_we, 0);
    chk("rst_m0_ack", m0_ack, 0);
    chk("rst_m1_ack", m1_ack, 0);
    tick();

    // Write 0xA5 to 0x005, then read it back.
    m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_addr = 10'h005; m0_wdata = 8'hA5;
    sample();
    chk("t1_idle_stall", m0_stall, 1);
    chk("t1_idle_en", bram_en, 0);
    tick();
    sample();
    chk("t1_en", bram_en, 1);
    chk("t1_we", bram_we, 1);
    chk("t1_addr", bram_addr, 10'h005);
    chk("t1_wdata", bram_wdata, 8'hA5);
    tick();
    m0_we = 0;
    sample();
    chk("t1_ack", m0_ack, 1);
    chk("t2_rd_en", bram_en, 1);
    chk("t2_rd_we", bram_we, 0);
    tick();
    m0_stb = 0;
    sample();
    chk("t2_ack", m0_ack, 1);
    chk("t2_rdata", m0_rdata, 8'hA5);
    chk("t2_m1_ack", m1_ack, 0);
    tick();
    m0_cyc = 0;
    cyc1();
    sample();
    chk("t2_idle_m0_stall", m0_stall, 1);
    tick();

    // Simultaneous requests: M0 first, then M1, then M0 again.
    reset = 1;
    cyc1();
    reset = 0;
    m0_cyc = 1; m1_cyc = 1; m1_stb = 1; m1_we = 0; m1_addr = 10'h3FF;
    cyc1();
    sample();
    chk("t3_m0_stall", m0_stall, 0);
    chk("t3_m1_stall", m1_stall, 1);
    chk("t3_no_m1_access", bram_en, 0);
    tick();
    cyc1();
    m0_cyc = 0;
    sample();
    chk("t3_m1_still_stalled", m1_stall, 1);
    tick();
    sample();
    chk("t3_gap_m0_stall", m0_stall, 1);
    chk("t3_gap_m1_stall", m1_stall, 1);
    tick();
    sample();
    chk("t3_own1_m1_stall", m1_stall, 0);
    chk("t3_own1_m0_stall", m0_stall, 1);
    chk("t3_own1_addr", bram_addr, 10'h3FF);
    tick();
    m1_stb = 0;
    sample();
    chk("t3_m1_ack", m1_ack, 1);
    chk("t3_m1_rdata", m1_rdata, 8'hC3);
    chk("t3_m0_ack", m0_ack, 0);
    tick();
    m1_cyc = 0;
    cyc1();
    m0_cyc = 1; m1_cyc = 1;
    cyc1();
    sample();
    chk("t3_tie2_m0_stall", m0_stall, 0);
    chk("t3_tie2_m1_stall", m1_stall, 1);
    tick();
    m0_cyc = 0; m1_cyc = 0;
    cyc1();
    cyc1();

    // Four-beat read burst.
    m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_addr = 10'h000;
    cyc1();
    for (int i = 0; i < 4; i++) begin
      sample();
      chk("t4_en", bram_en, 1);
      chk("t4_addr", bram_addr, i);
      chk("t4_stall", m0_stall, 0);
      if (i > 0) begin
        chk("t4_ack", m0_ack, 1);
        chk("t4_rdata", m0_rdata, exp4[i-1]);
      end
      tick();
      m0_addr = 10'(i + 1);
      if (i == 3) m0_stb = 0;
    end
    sample();
    chk("t4_last_ack", m0_ack, 1);
    chk("t4_last_rdata", m0_rdata, exp4[3]);
    chk("t4_end_en", bram_en, 0);
    tick();

    // Abort: strobe accepted, cyc dropped before the ack.
    m0_stb = 1; m0_addr = 10'h007;
    sample();
    chk("t5_en", bram_en, 1);
    tick();
    m0_cyc = 0; m0_stb = 0;
    sample();
    chk("t5_abort_ack", m0_ack, 0);
    tick();
    sample();
    chk("t5_idle_m0_stall", m0_stall, 1);
    chk("t5_idle_m1_stall", m1_stall, 1);
    tick();

    // Reset while M1 owns the port with accesses in flight.
    m1_cyc = 1;
    cyc1();
    m1_stb = 1; m1_we = 1; m1_addr = 10'h009; m1_wdata = 8'h77;
    sample();
    chk("t6_en", bram_en, 1);
    tick();
    reset = 1; m1_addr = 10'h00A; m1_wdata = 8'h88;
    cyc1();
    reset = 0; m1_stb = 0;
    sample();
    chk("t6_m1_ack", m1_ack, 0);
    chk("t6_m0_stall", m0_stall, 1);
    chk("t6_m1_stall", m1_stall, 1);
    chk("t6_en", bram_en, 0);
    chk("t6_we", bram_we, 0);
    tick();
    cyc1();
    m1_cyc = 0;
    cyc1();
    cyc1();

    // The write issued before reset must have reached the BRAM.
    m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_addr = 10'h009;
    cyc1();
    cyc1();
    m0_stb = 0;
    sample();
    chk("t6_readback", m0_rdata, 8'h77);
    tick();
    m0_cyc = 0;
    cyc1();
    cyc1();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
